// File: rtl/snake_pkg.sv
// Shared constants and perimeter geometry for the snake display animator.
// Maps a linear perimeter position onto a {digit, segment} pair.
package snake_pkg;

    localparam logic [2:0] SEG_A = 3'd6;
    localparam logic [2:0] SEG_B = 3'd5;
    localparam logic [2:0] SEG_C = 3'd4;
    localparam logic [2:0] SEG_D = 3'd3;
    localparam logic [2:0] SEG_E = 3'd2;
    localparam logic [2:0] SEG_F = 3'd1;
    localparam logic [2:0] SEG_G = 3'd0;

    localparam logic DIR_CW  = 1'b0;
    localparam logic DIR_CCW = 1'b1;

    typedef struct packed {
        logic [7:0] digit;
        logic [2:0] seg;
    } seg_loc_t;

    function automatic int perim_len(input int n);
        return 2 * n + 4;
    endfunction

    // Clockwise walk: top row left-to-right, right edge down, bottom row back, left edge up.
    function automatic seg_loc_t pos_to_seg(input int pos, input int n);
        seg_loc_t loc;
        loc.digit = '0;
        loc.seg   = SEG_A;
        if (pos < n) begin
            loc.digit = 8'(pos);
        end else if (pos == n) begin
            loc.digit = 8'(n - 1);
            loc.seg   = SEG_B;
        end else if (pos == n + 1) begin
            loc.digit = 8'(n - 1);
            loc.seg   = SEG_C;
        end else if (pos <= 2 * n + 1) begin
            loc.digit = 8'(2 * n + 1 - pos);
            loc.seg   = SEG_D;
        end else if (pos == 2 * n + 2) begin
            loc.seg   = SEG_E;
        end else begin
            loc.seg   = SEG_F;
        end
        return loc;
    endfunction

endpackage

// File: rtl/seg_scan_mux.sv
// Time-multiplexes per-digit segment patterns onto shared seg/com pins.
// One cycle from pattern/index to pins; free-running, no backpressure.
module seg_scan_mux #(
    parameter int N_DIGITS = 4,
    parameter int SCAN_DIV = 16384
) (
    input  logic                     i_clk,
    input  logic                     i_clear,
    input  logic [N_DIGITS-1:0][6:0] i_pat,
    output logic [6:0]               o_seg,
    output logic [N_DIGITS-1:0]      o_com
);
    localparam int SW = $clog2(SCAN_DIV + 1);
    localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic [SW-1:0]       r_cnt;
    logic [DW-1:0]       r_idx;
    logic [6:0]          r_seg;
    logic [N_DIGITS-1:0] r_com;
    logic                w_wrap;
    logic [N_DIGITS-1:0] w_onehot;

    assign w_wrap   = (r_cnt == SW'(SCAN_DIV - 1));
    // Digit 0 is the leftmost and lives on the top com bit.
    assign w_onehot = {1'b1, {(N_DIGITS-1){1'b0}}} >> r_idx;

    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_cnt <= '0;
            r_idx <= '0;
            r_seg <= '0;
            r_com <= '1;
        end else begin
            r_cnt <= w_wrap ? '0 : r_cnt + SW'(1);
            if (w_wrap) begin
                r_idx <= (r_idx == DW'(N_DIGITS - 1)) ? '0 : r_idx + DW'(1);
            end
            r_com <= ~w_onehot;
            r_seg <= i_pat[r_idx];
        end
    end

    assign o_seg = r_seg;
    assign o_com = r_com;

endmodule

// File: rtl/snake_scanner.sv
// Perimeter snake animator: prescaled stepping, reversal, pause, speeds and grow.
// seg/com follow head/len one cycle later; step/lap pulse one cycle after the tick.
module snake_scanner
    import snake_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int LEN      = 3,
    parameter int STEP_DIV = 8388608,
    parameter int SCAN_DIV = 16384
) (
    input  logic                clk,
    input  logic                clear,
    input  logic                run,
    input  logic                dir,
    input  logic                grow,
    input  logic [1:0]          speed,
    output logic [6:0]          seg,
    output logic [N_DIGITS-1:0] com,
    output logic                step,
    output logic                lap
);
    localparam int P    = perim_len(N_DIGITS);
    localparam int PW   = $clog2(P);
    localparam int CNTW = $clog2(STEP_DIV);
    localparam logic [PW:0] P_EXT = (PW+1)'(P);
    localparam logic [PW:0] ONE_E = (PW+1)'(1);

    logic [CNTW-1:0] r_presc;
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_len;
    logic            r_dir;
    logic            r_step;
    logic            r_lap;

    logic [CNTW-1:0] w_limit;
    logic            w_tick;
    logic [PW:0]     w_head_ext;
    logic [PW:0]     w_len_m1;
    logic [PW:0]     w_sum;
    logic [PW-1:0]   w_head_nxt;
    logic [PW-1:0]   w_len_nxt;
    logic            w_lap;
    logic [PW:0]     w_d;
    seg_loc_t        w_loc;
    logic [N_DIGITS-1:0][6:0] w_pat;

    assign w_limit    = CNTW'((STEP_DIV >> speed) - 1);
    assign w_tick     = run && (r_presc >= w_limit);
    assign w_head_ext = {1'b0, r_head};
    assign w_len_m1   = {1'b0, r_len} - ONE_E;

    always_comb begin
        w_sum     = w_head_ext;
        w_lap     = 1'b0;
        w_len_nxt = r_len;
        if (dir != r_dir) begin
            // Reversal jumps the head to the old tail so the lit set stays put.
            if (r_dir == DIR_CW) w_sum = w_head_ext + P_EXT - w_len_m1;
            else                 w_sum = w_head_ext + w_len_m1;
        end else if (r_dir == DIR_CW) begin
            w_sum = w_head_ext + ONE_E;
            w_lap = (r_head == PW'(P - 1));
        end else begin
            w_sum = w_head_ext + P_EXT - ONE_E;
            w_lap = (r_head == '0);
        end
        if (w_sum >= P_EXT) w_sum = w_sum - P_EXT;
        w_head_nxt = w_sum[PW-1:0];
        if (w_lap && grow) begin
            w_len_nxt = (r_len == PW'(P - 1)) ? PW'(1) : r_len + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_presc <= '0;
            r_head  <= '0;
            r_len   <= PW'(LEN);
            r_dir   <= DIR_CW;
            r_step  <= 1'b0;
            r_lap   <= 1'b0;
        end else begin
            r_step <= w_tick;
            r_lap  <= w_tick & w_lap;
            if (run) r_presc <= w_tick ? '0 : r_presc + CNTW'(1);
            if (w_tick) begin
                r_head <= w_head_nxt;
                r_len  <= w_len_nxt;
                r_dir  <= dir;
            end
        end
    end

    // Distance measured backwards along the direction of travel from the head.
    always_comb begin
        w_pat = '0;
        w_d   = '0;
        w_loc = '0;
        for (int p = 0; p < P; p++) begin
            if (r_dir == DIR_CW) w_d = w_head_ext + P_EXT - (PW+1)'(p);
            else                 w_d = (PW+1)'(p) + P_EXT - w_head_ext;
            if (w_d >= P_EXT) w_d = w_d - P_EXT;
            w_loc = pos_to_seg(p, N_DIGITS);
            w_pat[int'(w_loc.digit)][w_loc.seg] = (w_d < {1'b0, r_len});
        end
    end

    seg_scan_mux #(
        .N_DIGITS (N_DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .i_clk   (clk),
        .i_clear (clear),
        .i_pat   (w_pat),
        .o_seg   (seg),
        .o_com   (com)
    );

    assign step = r_step;
    assign lap  = r_lap;

endmodule
